// File: rtl/bf16_mul_sequencer.sv
// rtl/bf16_mul_sequencer.sv - iterative variable-precision BF16 multiply sequencer
// Optional round-to-nearest-even stage is enabled with BF16_MUL_ROUND_EN.
module bf16_mul_sequencer #(
  parameter int PREC_DEFAULT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_prec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  localparam logic [3:0] PREC_DEF4 = 4'(PREC_DEFAULT);

  logic [7:0]         sa, sb;
  logic [15:0]        p;
  logic [2:0]         cnt;
  logic [3:0]         n_r;
  logic               sign_r, spec_r;
  logic signed [9:0]  e_r;
  logic [15:0]        result_r;
  logic [3:0]         flags_r;

  // Accept-time decode
  logic [7:0]         ea, eb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               sign_in, spec_hit;
  logic [3:0]         prec_sel, n_in;
  logic signed [9:0]  e_in;
  logic [19:0]        spec_pack;

  always_comb begin
    ea       = in_a[14:7];
    eb       = in_b[14:7];
    a_zero   = (ea == 8'd0);
    b_zero   = (eb == 8'd0);
    a_inf    = (ea == 8'hFF) && (in_a[6:0] == 7'd0);
    b_inf    = (eb == 8'hFF) && (in_b[6:0] == 7'd0);
    a_nan    = (ea == 8'hFF) && (in_a[6:0] != 7'd0);
    b_nan    = (eb == 8'hFF) && (in_b[6:0] != 7'd0);
    sign_in  = in_a[15] ^ in_b[15];
    e_in     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    prec_sel = (in_prec == 4'd0) ? PREC_DEF4 : in_prec;
    if (prec_sel > 4'd8)
      n_in = 4'd8;
    else if (prec_sel == 4'd0)
      n_in = 4'd1;
    else
      n_in = prec_sel;
    spec_hit  = 1'b1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      spec_pack = {16'h7FC0, 4'b1000};
    else if (a_inf || b_inf)
      spec_pack = {sign_in, 8'hFF, 7'd0, 4'b0000};
    else if (a_zero || b_zero)
      spec_pack = {sign_in, 15'd0, 4'b0000};
    else begin
      spec_pack = 20'd0;
      spec_hit  = 1'b0;
    end
  end

  // One shift-add step per MUL cycle, B significand consumed MSB first
  logic [2:0]  bit_idx;
  logic [15:0] addend;
  logic        mul_last;

  always_comb begin
    bit_idx  = 3'd7 - cnt;
    addend   = sb[bit_idx] ? (16'(sa) << bit_idx) : 16'd0;
    mul_last = ({1'b0, cnt} == (n_r - 4'd1));
  end

  logic [6:0]        norm_mant;
  logic signed [9:0] norm_e;

  always_comb begin
    if (p[15]) begin
      norm_mant = p[14:8];
      norm_e    = e_r + 10'sd1;
    end else begin
      norm_mant = p[13:7];
      norm_e    = e_r;
    end
  end

  function automatic logic [19:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [6:0] m, input logic apx);
    if (e >= 10'sd255)
      pack = {s, 8'hFF, 7'd0, 3'b010, apx};
    else if (e <= 10'sd0)
      pack = {s, 15'd0, 3'b001, apx};
    else
      pack = {s, e[7:0], m, 3'b000, apx};
  endfunction

`ifdef BF16_MUL_ROUND_EN
  logic [6:0]        mant_r;
  logic              guard_r, sticky_r;
  logic              norm_guard, norm_sticky, rnd_inc;
  logic [7:0]        rnd_sum;
  logic [6:0]        rnd_mant;
  logic signed [9:0] rnd_e;

  always_comb begin
    norm_guard  = p[15] ? p[7] : p[6];
    norm_sticky = p[15] ? (|p[6:0]) : (|p[5:0]);
    rnd_inc     = guard_r & (sticky_r | mant_r[0]);
    rnd_sum     = {1'b0, mant_r} + {7'd0, rnd_inc};
    // Carry out of the fraction means the significand rolled over to 2.0
    rnd_mant    = rnd_sum[7] ? 7'd0 : rnd_sum[6:0];
    rnd_e       = rnd_sum[7] ? (e_r + 10'sd1) : e_r;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Specials use the NORM slot as their single pass-through cycle
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          state_nxt = spec_hit ? NORM : MUL;
      end
      MUL:   if (mul_last) state_nxt = NORM;
`ifdef BF16_MUL_ROUND_EN
      NORM:  state_nxt = spec_r ? DONE : ROUND;
      ROUND: state_nxt = DONE;
`else
      NORM:  state_nxt = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= 8'd0;
      sb       <= 8'd0;
      p        <= 16'd0;
      cnt      <= 3'd0;
      n_r      <= 4'd0;
      sign_r   <= 1'b0;
      spec_r   <= 1'b0;
      e_r      <= 10'sd0;
      result_r <= 16'd0;
      flags_r  <= 4'd0;
`ifdef BF16_MUL_ROUND_EN
      mant_r   <= 7'd0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa     <= {1'b1, in_a[6:0]};
          sb     <= {1'b1, in_b[6:0]};
          sign_r <= sign_in;
          n_r    <= n_in;
          e_r    <= e_in;
          p      <= 16'd0;
          cnt    <= 3'd0;
          spec_r <= spec_hit;
          if (spec_hit)
            {result_r, flags_r} <= spec_pack;
        end
        MUL: begin
          p   <= p + addend;
          cnt <= cnt + 3'd1;
        end
        NORM: if (!spec_r) begin
`ifdef BF16_MUL_ROUND_EN
          mant_r   <= norm_mant;
          e_r      <= norm_e;
          guard_r  <= norm_guard;
          sticky_r <= norm_sticky;
`else
          {result_r, flags_r} <= pack(sign_r, norm_e, norm_mant, n_r < 4'd8);
`endif
        end
`ifdef BF16_MUL_ROUND_EN
        ROUND: {result_r, flags_r} <= pack(sign_r, rnd_e, rnd_mant, n_r < 4'd8);
`endif
        default: ;
      endcase
    end
  end

  assign out_result = result_r;
  assign out_flags  = flags_r;

endmodule
